// File: rtl/pipe_pkg.sv
// Shared pipeline types: EX bypass-mux select encoding, destination-register
// record kept for the EX stage, and the forwarding controller's state set.
package pipe_pkg;

    localparam int unsigned REC_DEST_W = 5;

    localparam logic [1:0] FWD_REG   = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b10;
    localparam logic [1:0] FWD_MEMWB = 2'b01;

    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;

    typedef enum logic [0:0] {
        RUN  = ST_RUN,
        HOLD = ST_HOLD
    } fwd_state_e;

    typedef struct packed {
        logic [REC_DEST_W-1:0] dest;
        logic                  regwrite;
        logic                  memread;
    } fwd_rec_t;

    localparam fwd_rec_t REC_EMPTY = '0;

endpackage

// File: rtl/fwd_pick.sv
// Operand-select priority compare for one source register against the
// EX and MEM producer records; the younger (EX) producer wins.
module fwd_pick
    import pipe_pkg::*;
#(
    parameter int unsigned REG_W = 5
) (
    input  logic             uses_i,
    input  logic [REG_W-1:0] src_i,
    input  logic [REG_W-1:0] ex_dest_i,
    input  logic             ex_regwrite_i,
    input  logic [REG_W-1:0] mem_dest_i,
    input  logic             mem_regwrite_i,
    output logic [1:0]       sel_o
);

    logic ex_hit;
    logic mem_hit;

    always_comb begin
        // $0 is hardwired to zero, so a write to it never forwards.
        ex_hit  = ex_regwrite_i  && (ex_dest_i  != '0) && (ex_dest_i  == src_i);
        mem_hit = mem_regwrite_i && (mem_dest_i != '0) && (mem_dest_i == src_i);
        sel_o   = FWD_REG;
        if (uses_i && ex_hit) begin
            sel_o = FWD_EXMEM;
        end else if (uses_i && mem_hit) begin
            sel_o = FWD_MEMWB;
        end
    end

endmodule

// File: rtl/fwd_ctrl.sv
// Forwarding and load-use hazard controller for the 5-stage pipeline.
// Shadows EX/MEM destination info and registers the EX operand selects.
module fwd_ctrl
    import pipe_pkg::*;
#(
    parameter int unsigned REG_W = REC_DEST_W,
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic [REG_W-1:0] id_dest,
    input  logic             id_regwrite,
    input  logic             id_memread,
    input  logic             flush,
    output logic [1:0]       sel_a,
    output logic [1:0]       sel_b,
    output logic             stall,
    output logic             bubble,
    output logic [CNT_W-1:0] stall_cnt
);

    fwd_rec_t         ex_q, ex_d;
    logic [REG_W-1:0] mem_dest_q;
    logic             mem_regwrite_q;
    logic [1:0]       sel_a_q, sel_a_d;
    logic [1:0]       sel_b_q, sel_b_d;
    fwd_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [1:0]       pick_a;
    logic [1:0]       pick_b;
    logic             ex_load;
    logic             hz;
    logic             issue;

    fwd_pick #(.REG_W(REG_W)) u_pick_rs (
        .uses_i         (id_uses_rs),
        .src_i          (id_rs),
        .ex_dest_i      (ex_q.dest),
        .ex_regwrite_i  (ex_q.regwrite),
        .mem_dest_i     (mem_dest_q),
        .mem_regwrite_i (mem_regwrite_q),
        .sel_o          (pick_a)
    );

    fwd_pick #(.REG_W(REG_W)) u_pick_rt (
        .uses_i         (id_uses_rt),
        .src_i          (id_rt),
        .ex_dest_i      (ex_q.dest),
        .ex_regwrite_i  (ex_q.regwrite),
        .mem_dest_i     (mem_dest_q),
        .mem_regwrite_i (mem_regwrite_q),
        .sel_o          (pick_b)
    );

    always_comb begin
        ex_load = ex_q.memread && ex_q.regwrite && (ex_q.dest != '0);
        hz      = id_valid && ex_load &&
                  ((id_uses_rs && (ex_q.dest == id_rs)) ||
                   (id_uses_rt && (ex_q.dest == id_rt)));
    end

    // Flush beats the hazard: the ID instruction is discarded anyway.
    assign stall  = !rst && hz && !flush;
    assign bubble = !rst && (hz || flush);

    always_comb begin
        issue   = id_valid && !bubble;
        ex_d    = REC_EMPTY;
        sel_a_d = FWD_REG;
        sel_b_d = FWD_REG;
        if (issue) begin
            ex_d.dest     = id_dest;
            ex_d.regwrite = id_regwrite;
            ex_d.memread  = id_memread;
            sel_a_d       = pick_a;
            sel_b_d       = pick_b;
        end

        state_d = RUN;
        if (state_q == RUN && stall) begin
            state_d = HOLD;
        end

        cnt_d = cnt_q;
        if (stall && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q           <= REC_EMPTY;
            mem_dest_q     <= '0;
            mem_regwrite_q <= 1'b0;
            sel_a_q        <= FWD_REG;
            sel_b_q        <= FWD_REG;
            state_q        <= RUN;
            cnt_q          <= '0;
        end else begin
            // HOLD always follows a bubble into EX, so no hazard can be seen there.
            assert (!(state_q == HOLD && stall));
            ex_q           <= ex_d;
            mem_dest_q     <= ex_q.dest;
            mem_regwrite_q <= ex_q.regwrite;
            sel_a_q        <= sel_a_d;
            sel_b_q        <= sel_b_d;
            state_q        <= state_d;
            cnt_q          <= cnt_d;
        end
    end

    assign sel_a     = sel_a_q;
    assign sel_b     = sel_b_q;
    assign stall_cnt = cnt_q;

endmodule
